// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: memory-port arbitration, load-use bubbles,
// branch squash, halt freeze and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             mem_branch_taken,
   input  logic             mem_halt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             pc_en,
   output logic             ifid_stall,
   output logic             idex_stall,
   output logic             exmem_stall,
   output logic             memwb_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             imem_en,
   output logic             dmem_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {RUN, HALT} state_t;

   state_t           state_q, state_d;
   logic             d_done_q, d_done_d;
   logic             i_done_q, i_done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic run, dreq, d_ok, i_ok, advance, load_use, bubble;

   assign run      = (state_q == RUN);
   assign dreq     = mem_dREN | mem_dWEN;
   assign d_ok     = ~dreq | dhit | d_done_q;
   assign i_ok     = ihit | i_done_q;
   assign advance  = run & i_ok & d_ok;
   assign load_use = ex_memread & (ex_rd != '0) &
                     ((ex_rd == id_rs) | (ex_rd == id_rt));
   // Load-use bubble only fires when no taken branch squashes the ID slot
   assign bubble   = advance & ~mem_branch_taken & load_use;

   assign dmem_en     = run & dreq & ~d_done_q;
   assign imem_en     = run & ~i_done_q & ~(dreq & ~d_done_q);
   assign halted      = ~run;
   assign stall_count = cnt_q;

   always_comb begin
      pc_en       = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      memwb_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (!advance) begin
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_stall = 1'b1;
      end else if (mem_branch_taken) begin
         pc_en       = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (load_use) begin
         ifid_stall  = 1'b1;
         idex_flush  = 1'b1;
      end else begin
         pc_en       = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      d_done_d = d_done_q;
      i_done_d = i_done_q;
      cnt_d    = cnt_q;
      if (advance) begin
         d_done_d = 1'b0;
         i_done_d = 1'b0;
      end else begin
         if (dhit) d_done_d = 1'b1;
         if (ihit) i_done_d = 1'b1;
      end
      if (run && (!advance || bubble) && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
      if (advance && mem_halt)
         state_d = HALT;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= RUN;
         d_done_q <= 1'b0;
         i_done_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         d_done_q <= d_done_d;
         i_done_q <= i_done_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed plan plus random traffic
// against a behavioural model; 4-bit counter build to reach saturation.
module tb_pipe_hazard_ctrl;

   localparam int RW = 5;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          ihit, dhit, mem_dREN, mem_dWEN;
   logic          mem_branch_taken, mem_halt, ex_memread;
   logic [RW-1:0] ex_rd, id_rs, id_rt;
   logic          pc_en, ifid_stall, idex_stall, exmem_stall, memwb_stall;
   logic          ifid_flush, idex_flush, exmem_flush;
   logic          imem_en, dmem_en, halted;
   logic [CW-1:0] stall_count;

   always #5 CLK = ~CLK;

   pipe_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST),
      .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
      .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .id_rs(id_rs), .id_rt(id_rt),
      .pc_en(pc_en),
      .ifid_stall(ifid_stall), .idex_stall(idex_stall),
      .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush),
      .imem_en(imem_en), .dmem_en(dmem_en),
      .halted(halted), .stall_count(stall_count)
   );

   typedef logic [11+CW-1:0] vec_t;
   vec_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Behavioural model state
   bit m_frozen, m_data_held, m_fetch_held;
   int m_stalls;

   function automatic bit data_req();
      return mem_dREN || mem_dWEN;
   endfunction

   function automatic bit moves();
      bit mem_ready, fetch_ready;
      mem_ready   = !data_req() || dhit || m_data_held;
      fetch_ready = ihit || m_fetch_held;
      return !m_frozen && mem_ready && fetch_ready;
   endfunction

   function automatic bit hazard();
      if (!ex_memread || ex_rd == 0) return 0;
      return (ex_rd == id_rs) || (ex_rd == id_rt);
   endfunction

   // {pc, stall ifid/idex/exmem/memwb, flush ifid/idex/exmem, imem, dmem, halted, count}
   function automatic vec_t expect_now();
      bit pc, s1, s2, s3, s4, f1, f2, f3, im, dm;
      pc = 0; s1 = 0; s2 = 0; s3 = 0; s4 = 0;
      f1 = 0; f2 = 0; f3 = 0; im = 0; dm = 0;
      if (m_frozen) begin
         s1 = 1; s2 = 1; s3 = 1; s4 = 1;
      end else begin
         dm = data_req() && !m_data_held;
         im = !m_fetch_held && !dm;
         if (!moves()) begin
            s1 = 1; s2 = 1; s3 = 1; s4 = 1;
         end else if (mem_branch_taken) begin
            pc = 1; f1 = 1; f2 = 1; f3 = 1;
         end else if (hazard()) begin
            s1 = 1; f2 = 1;
         end else begin
            pc = 1;
         end
      end
      return {pc, s1, s2, s3, s4, f1, f2, f3, im, dm, m_frozen,
              CW'(m_stalls)};
   endfunction

   task automatic model_reset();
      m_frozen = 0; m_data_held = 0; m_fetch_held = 0; m_stalls = 0;
   endtask

   task automatic model_step();
      bit go;
      go = moves();
      if (!m_frozen) begin
         if ((!go || (!mem_branch_taken && hazard())) &&
             m_stalls < (1 << CW) - 1)
            m_stalls++;
         if (go && mem_halt) m_frozen = 1;
      end
      if (go) begin
         m_data_held = 0; m_fetch_held = 0;
      end else begin
         if (dhit) m_data_held = 1;
         if (ihit) m_fetch_held = 1;
      end
   endtask

   task automatic cycle(input bit rst, input bit dr, input bit dw,
                        input bit ih, input bit dh, input bit br,
                        input bit hl, input bit em,
                        input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                        input logic [RW-1:0] rt);
      @(posedge CLK);
      if (nRST) model_step();
      #1;
      nRST = !rst; mem_dREN = dr; mem_dWEN = dw; ihit = ih; dhit = dh;
      mem_branch_taken = br; mem_halt = hl; ex_memread = em;
      ex_rd = rd; id_rs = rs; id_rt = rt;
      if (rst) model_reset();
      exp_q.push_back(expect_now());
   endtask

   task automatic idle(input bit rst, input int n);
      for (int i = 0; i < n; i++)
         cycle(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         vec_t e, a;
         e = exp_q.pop_front();
         a = {pc_en, ifid_stall, idex_stall, exmem_stall, memwb_stall,
              ifid_flush, idex_flush, exmem_flush, imem_en, dmem_en,
              halted, stall_count};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL ctl @%0t: got %b want %b", $time, a, e);
         end
      end
   end

   initial begin
      nRST = 0; ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
      mem_branch_taken = 0; mem_halt = 0; ex_memread = 0;
      ex_rd = 0; id_rs = 0; id_rt = 0;
      model_reset();
      idle(1, 2);
      // Free-running fetch, no hazards
      for (int i = 0; i < 6; i++)
         cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2);
      // Load: dhit after 3 waits, ihit two cycles later
      for (int i = 0; i < 3; i++)
         cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      // Load-use on rt, then same with x0 destination
      cycle(0, 0, 0, 1, 0, 0, 0, 1, 8, 3, 8);
      cycle(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0, 1, 8, 8, 4);
      // Branch overrides load-use
      cycle(0, 0, 0, 1, 0, 1, 0, 1, 8, 8, 8);
      cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      // Halt, then activity is ignored until reset
      cycle(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 1, 1, 1, 0, 1, 5, 5, 5);
      idle(0, 3);
      idle(1, 1);
      cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      // Starved fetch saturates the counter
      idle(0, 20);
      cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1, 1);
      // Random traffic
      for (int i = 0; i < 800; i++) begin
         bit rst, dr, dw;
         rst = ($urandom_range(0, 59) == 0);
         dr  = ($urandom_range(0, 3) == 0);
         dw  = !dr && ($urandom_range(0, 5) == 0);
         cycle(rst, dr, dw,
               $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 1) == 1,
               RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
               RW'($urandom_range(0, 3)));
      end
      @(negedge CLK);
      @(negedge CLK);
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. Each cycle it decides whether the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC capture, hold or take a bubble. It arbitrates the single memory port between the instruction fetch and the MEM-stage data access, with data taking priority. It also inserts load-use bubbles, squashes wrong-path instructions on taken branches, freezes the core on halt and counts stall cycles.

## Interface
Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction memory returned the fetch this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- mem_dREN, mem_dWEN  in  1 each  MEM-stage data read/write request.
- mem_branch_taken  in  1  branch/jump in MEM resolved taken.
- mem_halt  in  1  halt instruction in MEM.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  REG_W  destination of the EX load.
- id_rs, id_rt  in  REG_W  sources of the ID instruction.
- pc_en  out  1  PC captures next PC.
- ifid_stall, idex_stall, exmem_stall, memwb_stall  out  1 each  hold latch.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load zero (bubble) into latch.
- imem_en, dmem_en  out  1 each  gate the instruction/data request to memory.
- halted  out  1  core frozen.
- stall_count  out  CNT_W  saturating count of non-progress cycles.

## Operation
- Registered state: fsm {RUN, HALT}, d_done, i_done, stall_count. All other outputs are combinational from state and inputs.
- dreq = mem_dREN | mem_dWEN.
- d_ok = !dreq | dhit | d_done.
- i_ok = ihit | i_done.
- advance = (fsm==RUN) & i_ok & d_ok.
- Memory arbitration (data first):
  - dmem_en = RUN & dreq & !d_done.
  - imem_en = RUN & !i_done & !(dreq & !d_done).
- d_done is set on dhit & !advance and cleared on advance. i_done follows the same rule with ihit. Each flag prevents a completed access from being reissued while the other side is still pending.
- load_use = ex_memread & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt).
- Latch control, in priority order:
  1. !advance: all four *_stall=1, pc_en=0, all flushes 0.
  2. advance & mem_branch_taken: pc_en=1; ifid_flush, idex_flush, exmem_flush=1; memwb captures. Load_use is ignored in this case.
  3. advance & load_use: pc_en=0, ifid_stall=1, idex_flush=1; exmem and memwb capture.
  4. advance otherwise: pc_en=1, no stalls, no flushes.
- Halt: advance & mem_halt lets memwb capture the halt, then fsm goes to HALT. Branch flush rules still apply in that same cycle. In HALT: halted=1, all stalls 1, pc_en=0, imem_en=dmem_en=0, no flushes. HALT is exited only by reset.
- stall_count increments in RUN on every cycle where !advance or the load_use bubble fires. It saturates at all-ones and holds in HALT.

## Timing
- Reset (async): fsm=RUN, d_done=i_done=0, stall_count=0. Latch controls with idle inputs are then all stalls=1, pc_en=0, flushes 0, halted=0, dmem_en=0, imem_en=1.
- Zero-cycle decision: a hit and the resulting latch update occur on the same rising edge.
- dhit and ihit in the same cycle: advance, both flags stay 0.
- dhit first, ihit N cycles later: d_done=1 from the cycle after dhit, and dmem_en=0 during the wait. Advance occurs in the ihit cycle, then d_done clears.
- ihit while dreq is pending is impossible under the enable gating. If it does occur, it is recorded in i_done regardless.
- Reset mid-wait clears the flags and any held access is abandoned. Reset in HALT returns to RUN.
- stall_count saturation: at 2^CNT_W-1 it holds and does not wrap.

## Test plan
- No dreq, ihit every cycle, no hazards -> pc_en=1 and no stalls every cycle; stall_count stays 0.
- Load with dREN, dhit after 3 cycles, ihit 2 cycles after that -> dmem_en drops after dhit, imem_en rises, advance occurs on the ihit cycle, stall_count=5.
- ex_memread=1, ex_rd=8, id_rt=8, ihit -> pc_en=0, ifid_stall=1, idex_flush=1, exmem/memwb capture, count+1. The same stimulus with ex_rd=0 produces no bubble.
- mem_branch_taken and load_use together on advance -> ifid/idex/exmem flushed, pc_en=1, no load-use bubble.
- mem_halt on advance -> next cycle halted=1, all stalls 1, both memory enables 0, count frozen. Asserting nRST returns to RUN with count 0.
- Force stall_count to near max (CNT_W=4 build), hold ihit=0 for 20 cycles -> count reaches 15 and holds.
